// File: rtl/mem_access_wb.sv
// Memory-access / write-back pipeline stage: issues byte/half/word loads and stores over a
// req/ack port, stalls upstream while an access is outstanding, and registers the RF write.
module mem_access_wb (
    input  logic        CLK,
    input  logic        RST,
    input  logic        InValid,
    input  logic [1:0]  RegDstIn,
    input  logic        RegWrIn,
    input  logic [1:0]  DigitIn,
    input  logic        DataWrIn,
    input  logic        immresIn,
    input  logic [1:0]  cmpIn,
    input  logic [4:0]  RdIn,
    input  logic [31:0] AluIn,
    input  logic [31:0] ImmIn,
    input  logic [31:0] PC4In,
    input  logic [31:0] StoreIn,
    input  logic        MemAck,
    input  logic [31:0] MemRData,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWData,
    output logic [3:0]  MemBe,
    output logic        Stall,
    output logic        WbValid,
    output logic        WbWe,
    output logic [4:0]  WbRd,
    output logic [31:0] WbData,
    output logic        Misalign
);
    // Handshake: MemReq rises with the request and stays high, with address/data/strobes
    // stable, until an edge samples MemAck=1; that edge retires the access.
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    state_t      state_q;
    logic        mem_req_q, mem_we_q, wb_valid_q, wb_we_q, misalign_q;
    logic [31:0] mem_addr_q, mem_wdata_q, wb_data_q;
    logic [3:0]  mem_be_q;
    logic [4:0]  wb_rd_q, rd_q;
    logic [1:0]  digit_q, lane_q;
    logic        regwr_q, store_q;

    logic        is_store, is_load, is_access, misalign_d;
    logic [3:0]  mem_be_d;
    logic [31:0] mem_wdata_d, wb_data_d, load_data_d;
    logic [15:0] half_v;
    logic [7:0]  byte_v;

    always_comb begin
        is_store  = DataWrIn;
        is_load   = ~DataWrIn & ~immresIn & (RegDstIn == 2'b01);
        is_access = is_load | is_store;
        misalign_d = ((DigitIn == 2'b01) & AluIn[0]) |
                     ((DigitIn == 2'b00) & (AluIn[1:0] != 2'b00));

        mem_be_d    = 4'b0001 << AluIn[1:0];
        mem_wdata_d = {4{StoreIn[7:0]}};
        if (DigitIn == 2'b00) begin
            mem_be_d    = 4'b1111;
            mem_wdata_d = StoreIn;
        end else if (DigitIn == 2'b01) begin
            mem_be_d    = AluIn[1] ? 4'b1100 : 4'b0011;
            mem_wdata_d = {2{StoreIn[15:0]}};
        end

        if (immresIn) begin
            wb_data_d = ImmIn;
        end else begin
            case (RegDstIn)
                2'b00:   wb_data_d = AluIn;
                2'b10:   wb_data_d = PC4In;
                2'b11:   wb_data_d = {31'b0, cmpIn == 2'b01};
                default: wb_data_d = AluIn;
            endcase
        end

        // Lane selection uses the byte offset captured when the request was issued.
        half_v = lane_q[1] ? MemRData[31:16] : MemRData[15:0];
        byte_v = MemRData[{lane_q, 3'b000} +: 8];
        case (digit_q)
            2'b00:   load_data_d = MemRData;
            2'b01:   load_data_d = {{16{half_v[15]}}, half_v};
            2'b10:   load_data_d = {{24{byte_v[7]}}, byte_v};
            default: load_data_d = {24'b0, byte_v};
        endcase
    end

    always_ff @(negedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            misalign_q  <= 1'b0;
            rd_q        <= '0;
            digit_q     <= '0;
            lane_q      <= '0;
            regwr_q     <= 1'b0;
            store_q     <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            wb_we_q    <= 1'b0;
            misalign_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (InValid) begin
                        if (!is_access) begin
                            wb_valid_q <= 1'b1;
                            wb_we_q    <= RegWrIn;
                            wb_rd_q    <= RdIn;
                            wb_data_q  <= wb_data_d;
                        end else if (misalign_d) begin
                            wb_valid_q <= 1'b1;
                            misalign_q <= 1'b1;
                        end else begin
                            digit_q     <= DigitIn;
                            lane_q      <= AluIn[1:0];
                            rd_q        <= RdIn;
                            regwr_q     <= RegWrIn;
                            store_q     <= is_store;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= is_store;
                            mem_addr_q  <= {AluIn[31:2], 2'b00};
                            mem_be_q    <= mem_be_d;
                            mem_wdata_q <= mem_wdata_d;
                            state_q     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (MemAck) begin
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                        mem_be_q   <= 4'b0000;
                        wb_valid_q <= 1'b1;
                        state_q    <= IDLE;
                        if (!store_q) begin
                            wb_we_q   <= regwr_q;
                            wb_rd_q   <= rd_q;
                            wb_data_q <= load_data_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign MemReq   = mem_req_q;
    assign MemWe    = mem_we_q;
    assign MemAddr  = mem_addr_q;
    assign MemWData = mem_wdata_q;
    assign MemBe    = mem_be_q;
    assign Stall    = (state_q == WAIT);
    assign WbValid  = wb_valid_q;
    assign WbWe     = wb_we_q;
    assign WbRd     = wb_rd_q;
    assign WbData   = wb_data_q;
    assign Misalign = misalign_q;
endmodule

// File: tb/tb_mem_access_wb.sv
// Directed bench for mem_access_wb: inputs change and outputs are sampled on the rising
// edge, half a cycle away from the falling edge the stage updates on.
module tb_mem_access_wb;
    logic        CLK = 1'b1;
    logic        RST, InValid, RegWrIn, DataWrIn, immresIn, MemAck;
    logic [1:0]  RegDstIn, DigitIn, cmpIn;
    logic [4:0]  RdIn;
    logic [31:0] AluIn, ImmIn, PC4In, StoreIn, MemRData;
    logic        MemReq, MemWe, Stall, WbValid, WbWe, Misalign;
    logic [31:0] MemAddr, MemWData, WbData;
    logic [3:0]  MemBe;
    logic [4:0]  WbRd;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    mem_access_wb dut (
        .CLK(CLK), .RST(RST), .InValid(InValid), .RegDstIn(RegDstIn), .RegWrIn(RegWrIn),
        .DigitIn(DigitIn), .DataWrIn(DataWrIn), .immresIn(immresIn), .cmpIn(cmpIn),
        .RdIn(RdIn), .AluIn(AluIn), .ImmIn(ImmIn), .PC4In(PC4In), .StoreIn(StoreIn),
        .MemAck(MemAck), .MemRData(MemRData), .MemReq(MemReq), .MemWe(MemWe),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemBe(MemBe), .Stall(Stall),
        .WbValid(WbValid), .WbWe(WbWe), .WbRd(WbRd), .WbData(WbData), .Misalign(Misalign)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One active (falling) edge, then return at the following rising edge.
    task automatic tick();
        @(negedge CLK);
        @(posedge CLK);
    endtask

    task automatic set_op(input logic [1:0] regdst, input logic regwr, input logic [1:0] digit,
                          input logic datawr, input logic immres, input logic [4:0] rd,
                          input logic [31:0] alu);
        InValid  = 1'b1;
        RegDstIn = regdst;
        RegWrIn  = regwr;
        DigitIn  = digit;
        DataWrIn = datawr;
        immresIn = immres;
        RdIn     = rd;
        AluIn    = alu;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_memreq"}, {31'b0, MemReq}, 32'd0);
        check({tag, "_stall"},  {31'b0, Stall},  32'd0);
    endtask

    initial begin
        RST = 1'b1; MemAck = 1'b0; MemRData = '0; cmpIn = 2'b00;
        ImmIn = 32'h0; PC4In = 32'h0; StoreIn = 32'h0;
        @(posedge CLK);
        set_op(2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 5'd5, 32'h1234);
        tick();
        tick();
        check("rst_memreq",   {31'b0, MemReq},   32'd0);
        check("rst_memwe",    {31'b0, MemWe},    32'd0);
        check("rst_memaddr",  MemAddr,           32'd0);
        check("rst_memwdata", MemWData,          32'd0);
        check("rst_membe",    {28'b0, MemBe},    32'd0);
        check("rst_stall",    {31'b0, Stall},    32'd0);
        check("rst_wbvalid",  {31'b0, WbValid},  32'd0);
        check("rst_wbwe",     {31'b0, WbWe},     32'd0);
        check("rst_wbrd",     {27'b0, WbRd},     32'd0);
        check("rst_wbdata",   WbData,            32'd0);
        check("rst_misalign", {31'b0, Misalign}, 32'd0);

        // Non-memory write-back sources
        RST = 1'b0;
        tick();
        check("alu_wbvalid", {31'b0, WbValid}, 32'd1);
        check("alu_wbwe",    {31'b0, WbWe},    32'd1);
        check("alu_wbrd",    {27'b0, WbRd},    32'd5);
        check("alu_wbdata",  WbData,           32'h1234);
        check_idle_outputs("alu");
        immresIn = 1'b1; ImmIn = 32'hABCD; RdIn = 5'd6;
        tick();
        check("imm_wbdata", WbData, 32'hABCD);
        check("imm_wbrd", {27'b0, WbRd}, 32'd6);
        immresIn = 1'b0; RegDstIn = 2'b11; cmpIn = 2'b01;
        tick();
        check("cmp_less", WbData, 32'd1);
        cmpIn = 2'b10;
        tick();
        check("cmp_greater", WbData, 32'd0);
        RegDstIn = 2'b10; PC4In = 32'h0000_4008; RegWrIn = 1'b0;
        tick();
        check("pc4_wbdata", WbData, 32'h0000_4008);
        check("pc4_wbwe", {31'b0, WbWe}, 32'd0);
        InValid = 1'b0;
        tick();
        check("novalid_wbvalid", {31'b0, WbValid}, 32'd0);
        check("novalid_hold", WbData, 32'h0000_4008);
        check_idle_outputs("novalid");

        // Signed byte load, ack sampled on the 3rd edge after acceptance
        set_op(2'b01, 1'b1, 2'b10, 1'b0, 1'b0, 5'd7, 32'h103);
        tick();
        check("lbs_memreq", {31'b0, MemReq}, 32'd1);
        check("lbs_memwe",  {31'b0, MemWe},  32'd0);
        check("lbs_addr",   MemAddr,         32'h100);
        check("lbs_stall0", {31'b0, Stall},  32'd1);
        check("lbs_wbvalid0", {31'b0, WbValid}, 32'd0);
        set_op(2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 5'd9, 32'h55);
        tick();
        check("lbs_stall1", {31'b0, Stall},  32'd1);
        check("lbs_wbvalid1", {31'b0, WbValid}, 32'd0);
        tick();
        check("lbs_stall2", {31'b0, Stall},  32'd1);
        check("lbs_req2",   {31'b0, MemReq}, 32'd1);
        MemAck = 1'b1; MemRData = 32'h80FF_0000;
        tick();
        MemAck = 1'b0;
        check("lbs_wbvalid", {31'b0, WbValid}, 32'd1);
        check("lbs_wbwe",    {31'b0, WbWe},    32'd1);
        check("lbs_wbrd",    {27'b0, WbRd},    32'd7);
        check("lbs_wbdata",  WbData,           32'hFFFF_FF80);
        check("lbs_membe",   {28'b0, MemBe},   32'd0);
        check_idle_outputs("lbs_done");
        tick();
        check("held_wbrd",   {27'b0, WbRd}, 32'd9);
        check("held_wbdata", WbData,        32'h55);

        // Unsigned byte load, minimum latency
        set_op(2'b01, 1'b1, 2'b11, 1'b0, 1'b0, 5'd8, 32'h103);
        tick();
        InValid = 1'b0; MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        check("lbu_wbdata", WbData, 32'h0000_0080);
        check("lbu_wbrd", {27'b0, WbRd}, 32'd8);

        // Signed half load from the upper lane
        set_op(2'b01, 1'b1, 2'b01, 1'b0, 1'b0, 5'd10, 32'h102);
        tick();
        InValid = 1'b0; MemAck = 1'b1; MemRData = 32'h8001_1234;
        tick();
        MemAck = 1'b0;
        check("lh_wbdata", WbData, 32'hFFFF_8001);

        // Word load
        set_op(2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 5'd11, 32'h104);
        tick();
        check("lw_addr", MemAddr, 32'h104);
        InValid = 1'b0; MemAck = 1'b1; MemRData = 32'hCAFE_F00D;
        tick();
        MemAck = 1'b0;
        check("lw_wbdata", WbData, 32'hCAFE_F00D);

        // Half store
        StoreIn = 32'hDEAD_BEEF;
        set_op(2'b00, 1'b0, 2'b01, 1'b1, 1'b0, 5'd0, 32'h202);
        tick();
        check("sh_memreq", {31'b0, MemReq}, 32'd1);
        check("sh_memwe",  {31'b0, MemWe},  32'd1);
        check("sh_addr",   MemAddr,         32'h200);
        check("sh_be",     {28'b0, MemBe},  32'hC);
        check("sh_wdata",  MemWData,        32'hBEEF_BEEF);
        InValid = 1'b0; MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        check("sh_wbvalid", {31'b0, WbValid}, 32'd1);
        check("sh_wbwe",    {31'b0, WbWe},    32'd0);
        check("sh_memwe_off", {31'b0, MemWe}, 32'd0);

        // Byte store at offset 1
        set_op(2'b00, 1'b0, 2'b10, 1'b1, 1'b0, 5'd0, 32'h201);
        tick();
        check("sb_be",    {28'b0, MemBe}, 32'h2);
        check("sb_wdata", MemWData,       32'hEFEF_EFEF);
        InValid = 1'b0; MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        check("sb_wbwe", {31'b0, WbWe}, 32'd0);

        // Misaligned word load is dropped
        set_op(2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 5'd12, 32'h101);
        tick();
        check("mis_memreq",   {31'b0, MemReq},   32'd0);
        check("mis_flag",     {31'b0, Misalign}, 32'd1);
        check("mis_wbvalid",  {31'b0, WbValid},  32'd1);
        check("mis_wbwe",     {31'b0, WbWe},     32'd0);
        check("mis_stall",    {31'b0, Stall},    32'd0);
        InValid = 1'b0;
        tick();
        check("mis_flag_off", {31'b0, Misalign}, 32'd0);

        // Reset while waiting abandons the access
        set_op(2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 5'd13, 32'h300);
        tick();
        check("rw_memreq", {31'b0, MemReq}, 32'd1);
        InValid = 1'b0; RST = 1'b1;
        tick();
        check("rw_memreq_off", {31'b0, MemReq},  32'd0);
        check("rw_stall",      {31'b0, Stall},   32'd0);
        check("rw_wbvalid",    {31'b0, WbValid}, 32'd0);
        RST = 1'b0; MemAck = 1'b1;
        tick();
        MemAck = 1'b0;
        check("rw_late_ack_wbvalid", {31'b0, WbValid}, 32'd0);
        check("rw_late_ack_memreq",  {31'b0, MemReq},  32'd0);
        set_op(2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 5'd3, 32'h77);
        tick();
        check("rw_next_wbvalid", {31'b0, WbValid}, 32'd1);
        check("rw_next_wbrd",    {27'b0, WbRd},    32'd3);
        check("rw_next_wbdata",  WbData,           32'h77);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_wb.md
# mem_access_wb

Memory-access and write-back stage of the five-stage pipeline CPU, directly downstream of the MEM control pipeline register. It consumes the latched MEM/WB control (RegDst, RegWr, Digit, DataWr, immres, cmp) plus datapath values, performs byte/half/word loads and stores over a request/acknowledge data-memory port, stalls upstream while an access is outstanding, and presents a registered register-file write (WbValid/WbWe/WbRd/WbData).

## Interface
- No parameters; data width fixed at 32, register index at 5.
- CLK  in  1  pipeline clock; all state updates on the falling edge, as in the other pipeline stages
- RST  in  1  synchronous, active-high reset, sampled on the falling edge of CLK
- InValid  in  1  upstream stage holds a valid instruction
- RegDstIn  in  2  write-back source: 00 ALU, 01 load data, 10 PC+4, 11 compare flag
- RegWrIn  in  1  register-file write enable
- DigitIn  in  2  access size: 00 word, 01 half signed, 10 byte signed, 11 byte unsigned
- DataWrIn  in  1  store
- immresIn  in  1  write ImmIn directly (overrides RegDstIn)
- cmpIn  in  2  compare result: 00 equal, 01 less, 10 greater
- RdIn  in  5  destination register
- AluIn, ImmIn, PC4In, StoreIn  in  32 each  ALU result/address, immediate, PC+4, store data
- MemAck  in  1  memory completes the outstanding request
- MemRData  in  32  read data, valid with MemAck
- MemReq, MemWe  out  1 each  request, write strobe
- MemAddr  out  32  word-aligned address ({AluIn[31:2],2'b00})
- MemWData  out  32  lane-replicated store data
- MemBe  out  4  byte enables
- Stall  out  1  hold upstream stage
- WbValid, WbWe  out  1 each  result valid this cycle; register-file write enable
- WbRd  out  5  destination register
- WbData  out  32  write-back value
- Misalign  out  1  one-cycle flag for a dropped misaligned access

## Operation
- States: IDLE, WAIT. Stall = (state==WAIT), combinational.
- Classification at IDLE: store = DataWrIn; load = ~DataWrIn & ~immresIn & RegDstIn==01; access = load|store.
- Misaligned: half with AluIn[0]=1, word with AluIn[1:0]!=0. No MemReq; WbValid=1, WbWe=0, Misalign=1 for one cycle.
- IDLE, InValid & ~access: WbValid=1, WbWe=RegWrIn, WbRd=RdIn, WbData = ImmIn if immresIn, else per RegDstIn (11 -> {31'b0, cmpIn==2'b01}).
- IDLE, InValid & aligned access: latch Digit, AluIn[1:0], RdIn, RegWrIn, store flag; drive MemReq=1, MemWe=store, MemAddr, MemBe, MemWData; go WAIT; WbValid=0.
- Store lanes (little-endian): word Be=1111, WData=StoreIn; half Be=AluIn[1]?1100:0011, WData={2{StoreIn[15:0]}}; byte Be=0001<<AluIn[1:0], WData={4{StoreIn[7:0]}}.
- WAIT: MemReq/outputs held stable; input ignored. On edge sampling MemAck=1: MemReq=MemWe=0, MemBe=0, state IDLE, WbValid=1. Load: WbWe=latched RegWr, WbData = lane extracted by latched addr[1:0], sign- or zero-extended per Digit. Store: WbWe=0.
- MemAck in IDLE is ignored.
- WbValid, WbWe, Misalign are single-cycle pulses; WbRd/WbData hold until next result.

## Timing
- Reset: state IDLE; every output 0 (MemReq, MemWe, MemAddr, MemWData, MemBe, Stall, WbValid, WbWe, WbRd, WbData, Misalign).
- RST mid-WAIT: request abandoned, MemReq 0 after that edge, no write-back; a later MemAck is ignored.
- Non-memory result: visible after the accepting edge (1-edge latency).
- Access accepted at edge N: MemReq high after N, Stall high after N; upstream advances at N (Stall was low) and then holds its next instruction.
- Ack sampled at edge M: result visible after M, Stall low after M; held upstream instruction accepted at M+1. Minimum memory latency M=N+1 (2 edges total).
- InValid=0 in IDLE: WbValid=0, no request.

## Test plan
- Reset: RST=1 for 2 edges with InValid=1 -> all outputs 0, state IDLE.
- ALU op RegDst=00, RegWr=1, Rd=5, AluIn=0x1234 -> next edge WbValid=1, WbWe=1, WbRd=5, WbData=0x1234; immres=1, ImmIn=0xABCD -> WbData=0xABCD; RegDst=11, cmp=01 -> WbData=1.
- Load byte signed, AluIn=0x103, MemAck after 3 cycles with MemRData=0x80FF_0000 -> Stall high 3 cycles, MemAddr=0x100, WbData=0xFFFF_FF80; byte unsigned -> 0x0000_0080.
- Store half, AluIn=0x202, StoreIn=0xDEAD_BEEF -> MemWe=1, MemBe=1100, MemWData=0xBEEF_BEEF; after ack WbValid=1, WbWe=0.
- Word load at AluIn=0x101 -> no MemReq, Misalign=1 one cycle, WbWe=0.
- RST asserted in WAIT, MemAck one cycle later -> MemReq 0, no WbValid, next instruction executes normally.
